// File: rtl/ppu_cpu_port.sv
// CPU-side register port of the Dendy PPU ($2000-$2007) plus the $4014 OAM DMA engine.
// Optional build macro: PPU_PALETTE_MIRROR_EN folds sprite backdrop palette entries onto $3F00/$04/$08/$0C.
module ppu_cpu_port #(
   parameter int INC_WIDE = 32,
   parameter int DMA_LEN  = 256
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [2:0]  cpu_a,
   input  logic        cpu_sel,
   input  logic        cpu_we,
   input  logic [7:0]  cpu_d,
   output logic [7:0]  cpu_q,
   input  logic        vbl_set,
   output logic [7:0]  ctrl,
   output logic [7:0]  mask,
   output logic [7:0]  scroll_x,
   output logic [7:0]  scroll_y,
   output logic        nmi,
   output logic [13:0] vram_a,
   output logic [7:0]  vram_d,
   output logic        vram_w,
   input  logic [7:0]  vram_i,
   output logic [7:0]  oam_a,
   output logic [7:0]  oam_d,
   output logic        oam_w,
   input  logic [7:0]  oam_i,
   input  logic        dma_req,
   input  logic [7:0]  dma_page,
   output logic [15:0] dma_a,
   input  logic [7:0]  dma_i,
   output logic        dma_busy
);

   typedef enum logic [1:0] {DMA_IDLE, DMA_RD, DMA_WR} dma_state_t;

   localparam logic [7:0] DMA_LAST = 8'(DMA_LEN - 1);

   dma_state_t  dma_state, dma_state_nx;
   logic [7:0]  dma_pg, dma_n;
   logic [13:0] v, v_inc;
   logic [7:0]  oam_addr, rd_buf;
   logic        w, vblank, buf_pend;
   logic        acc_wr, acc_rd, cpu_oam_w;

   // The CPU is stalled while DMA owns the port, so its strobes are dropped outright.
   assign dma_busy  = (dma_state != DMA_IDLE);
   assign acc_wr    = cpu_sel & cpu_we & ~dma_busy;
   assign acc_rd    = cpu_sel & ~cpu_we & ~dma_busy;
   assign cpu_oam_w = acc_wr && (cpu_a == 3'd4);
   assign v_inc     = v + (ctrl[2] ? 14'(INC_WIDE) : 14'd1);
   assign nmi       = vblank & ctrl[7];
   assign vram_w    = acc_wr && (cpu_a == 3'd7);
   assign vram_d    = vram_w ? cpu_d : 8'h00;

`ifdef PPU_PALETTE_MIRROR_EN
   assign vram_a = (v[13:8] == 6'h3F && v[4] && v[1:0] == 2'b00) ? {v[13:5], 1'b0, v[3:0]} : v;
`else
   assign vram_a = v;
`endif

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         ctrl     <= 8'h00;
         mask     <= 8'h00;
         scroll_x <= 8'h00;
         scroll_y <= 8'h00;
         cpu_q    <= 8'h00;
         v        <= 14'h0000;
         w        <= 1'b0;
         vblank   <= 1'b0;
         rd_buf   <= 8'h00;
         buf_pend <= 1'b0;
         oam_addr <= 8'h00;
      end else begin
         // Memory data for a $2007 read arrives one cycle after the address was issued.
         buf_pend <= 1'b0;
         if (buf_pend)
            rd_buf <= vram_i;

         if (vbl_set)
            vblank <= 1'b1;
         else if (acc_rd && cpu_a == 3'd2)
            vblank <= 1'b0;

         if (acc_wr) begin
            case (cpu_a)
               3'd0: ctrl     <= cpu_d;
               3'd1: mask     <= cpu_d;
               3'd3: oam_addr <= cpu_d;
               3'd4: oam_addr <= oam_addr + 8'd1;
               3'd5: begin
                  if (!w) scroll_x <= cpu_d;
                  else    scroll_y <= cpu_d;
                  w <= ~w;
               end
               3'd6: begin
                  if (!w) v[13:8] <= cpu_d[5:0];
                  else    v[7:0]  <= cpu_d;
                  w <= ~w;
               end
               3'd7: v <= v_inc;
               default: ;
            endcase
         end

         if (acc_rd) begin
            case (cpu_a)
               3'd2: begin
                  cpu_q <= {vblank & ~vbl_set, 7'b0};
                  w     <= 1'b0;
               end
               3'd4: cpu_q <= oam_i;
               3'd7: begin
                  cpu_q    <= (v >= 14'h3F00) ? vram_i : rd_buf;
                  buf_pend <= 1'b1;
                  v        <= v_inc;
               end
               default: cpu_q <= 8'h00;
            endcase
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         dma_state <= DMA_IDLE;
         dma_pg    <= 8'h00;
         dma_n     <= 8'h00;
      end else begin
         dma_state <= dma_state_nx;
         if (dma_state == DMA_IDLE && dma_req) begin
            dma_pg <= dma_page;
            dma_n  <= 8'h00;
         end else if (dma_state == DMA_WR) begin
            dma_n <= dma_n + 8'd1;
         end
      end
   end

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      dma_state_nx = dma_state;
      dma_a        = 16'h0000;
      oam_w        = cpu_oam_w;
      oam_a        = oam_addr;
      oam_d        = cpu_oam_w ? cpu_d : 8'h00;
      case (dma_state)
         DMA_IDLE: if (dma_req) dma_state_nx = DMA_RD;
         DMA_RD: begin
            dma_a        = {dma_pg, dma_n};
            dma_state_nx = DMA_WR;
         end
         DMA_WR: begin
            oam_w        = 1'b1;
            oam_a        = oam_addr + dma_n;
            oam_d        = dma_i;
            dma_state_nx = (dma_n == DMA_LAST) ? DMA_IDLE : DMA_RD;
         end
         default: dma_state_nx = DMA_IDLE;
      endcase
   end

endmodule
